// File: rtl/mat_mult_pkg.sv
// ============================================================================
// Module   : mat_mult_pkg
// Brief    : Shared types and width helpers for the streaming matrix multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mat_mult_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } mm_state_t;

    // Result width that can hold a full N-term dot product without overflow.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mat_mac.sv
// ============================================================================
// Module   : mat_mac
// Brief    : Single multiplier plus accumulator. The accumulator restarts when
//            first_i is high. Define MATMUL_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_mac
    import mat_mult_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             first_i,
    input  logic [DW-1:0]    a_i,
    input  logic [DW-1:0]    b_i,
    output logic [ACC_W-1:0] sum_o
);

    localparam int PW = 2 * DW;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] acc_q;

    // Operands are widened to the full product width first, so the low PW
    // bits of the product are exact for both signed and unsigned operands.
`ifdef MATMUL_SIGNED_EN
    assign w_a_ext    = {{DW{a_i[DW-1]}}, a_i};
    assign w_b_ext    = {{DW{b_i[DW-1]}}, b_i};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
`else
    assign w_a_ext    = {{DW{1'b0}}, a_i};
    assign w_b_ext    = {{DW{1'b0}}, b_i};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_W-PW){1'b0}}, w_prod};
`endif

    assign sum_o = (first_i ? '0 : acc_q) + w_prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mat_mult_stream.sv
// ============================================================================
// Module   : mat_mult_stream
// Brief    : Streaming N x N matrix multiply C = A x B. Elements are loaded
//            through a valid/ready stream, multiplied on one MAC and drained.
//            MATMUL_SIGNED_EN (in mat_mac) selects signed arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_mult_stream
    import mat_mult_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = acc_width(DW, N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int NN = N * N;
    localparam int KW = idx_w(N);
    localparam int MW = idx_w(NN);
    localparam int EW = idx_w(2 * NN);

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [MW-1:0] M_LAST = MW'(NN - 1);
    localparam logic [EW-1:0] E_LAST = EW'(2 * NN - 1);
    localparam logic [EW-1:0] E_B0   = EW'(NN);

    mm_state_t        state_q;
    logic [EW-1:0]    elem_q;
    logic [KW-1:0]    i_q;
    logic [KW-1:0]    j_q;
    logic [KW-1:0]    k_q;
    logic [MW-1:0]    idx_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_data_q;
    logic             busy_q;
    logic             done_q;

    logic [DW-1:0]    a_q [NN];
    logic [DW-1:0]    b_q [NN];
    logic [ACC_W-1:0] c_q [NN];

    logic             w_in_fire;
    logic             w_mac_step;
    logic [MW-1:0]    w_a_idx;
    logic [MW-1:0]    w_b_idx;
    logic [MW-1:0]    w_c_idx;
    logic [ACC_W-1:0] w_sum;

    assign in_ready  = ena && (state_q == LOAD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // clear wins over any handshake or MAC step in the same cycle.
    assign w_in_fire  = in_valid && in_ready && !clear;
    assign w_mac_step = ena && !clear && (state_q == CALC);

    assign w_a_idx = MW'(int'(i_q) * N + int'(k_q));
    assign w_b_idx = MW'(int'(k_q) * N + int'(j_q));
    assign w_c_idx = MW'(int'(i_q) * N + int'(j_q));

    mat_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (w_mac_step),
        .first_i (k_q == '0),
        .a_i     (a_q[w_a_idx]),
        .b_i     (b_q[w_b_idx]),
        .sum_o   (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NN; m++) begin
                a_q[m] <= '0;
                b_q[m] <= '0;
                c_q[m] <= '0;
            end
        end else begin
            if (w_in_fire) begin
                if (elem_q < E_B0) begin
                    a_q[MW'(elem_q)] <= in_data;
                end else begin
                    b_q[MW'(elem_q - E_B0)] <= in_data;
                end
            end
            if (w_mac_step && (k_q == K_LAST)) begin
                c_q[w_c_idx] <= w_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            elem_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (ena) begin
            done_q <= 1'b0;
            if (clear) begin
                state_q     <= LOAD;
                elem_q      <= '0;
                i_q         <= '0;
                j_q         <= '0;
                k_q         <= '0;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (in_valid) begin
                            if (elem_q == E_LAST) begin
                                elem_q  <= '0;
                                state_q <= CALC;
                                busy_q  <= 1'b1;
                            end else begin
                                elem_q <= elem_q + 1'b1;
                            end
                        end
                    end
                    CALC: begin
                        if (k_q != K_LAST) begin
                            k_q <= k_q + 1'b1;
                        end else begin
                            k_q <= '0;
                            if (j_q != K_LAST) begin
                                j_q <= j_q + 1'b1;
                            end else begin
                                j_q <= '0;
                                if (i_q != K_LAST) begin
                                    i_q <= i_q + 1'b1;
                                end else begin
                                    // C[0] was written long before the final MAC step.
                                    i_q         <= '0;
                                    idx_q       <= '0;
                                    state_q     <= DRAIN;
                                    out_valid_q <= 1'b1;
                                    out_data_q  <= c_q[0];
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_ready) begin
                            if (idx_q == M_LAST) begin
                                idx_q       <= '0;
                                state_q     <= LOAD;
                                out_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                idx_q      <= idx_q + 1'b1;
                                out_data_q <= c_q[idx_q + 1'b1];
                            end
                        end
                    end
                    default: begin
                        state_q <= LOAD;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mat_mult_stream.sv
// ============================================================================
// Module   : tb_mat_mult_stream
// Brief    : Directed self-checking bench for mat_mult_stream with N=2, DW=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mat_mult_stream;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] stim [8];
    logic [AW-1:0] expv [4];

    mat_mult_stream #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams stim[0..7]; the final step() is the acceptance edge T.
    task automatic load(input bit gaps);
        for (int e = 0; e < 8; e++) begin
            if (gaps && (e % 3 == 1)) begin
                in_valid = 1'b0;
                step();
                step();
            end
            in_valid = 1'b1;
            in_data  = stim[e];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic drain(input bit bp);
        for (int m = 0; m < 4; m++) begin
            if (bp) begin
                out_ready = 1'b0;
                step();
                check_bit("stall_valid", out_valid, 1'b1);
                check_data($sformatf("stall_data%0d", m), out_data, expv[m]);
            end
            check_bit($sformatf("valid%0d", m), out_valid, 1'b1);
            check_data($sformatf("out%0d", m), out_data, expv[m]);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check_bit("done_pulse", done, 1'b1);
        check_bit("ready_with_done", in_ready, 1'b1);
        check_bit("busy_after_drain", busy, 1'b0);
        check_bit("valid_after_drain", out_valid, 1'b0);
        step();
        check_bit("done_one_cycle", done, 1'b0);
    endtask

    task automatic set_known();
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        expv = '{17'd19, 17'd22, 17'd43, 17'd50};
    endtask

    initial begin
        int lat;
        int quiet;

        // Reset with ena low
        step();
        step();
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_data("rst_out_data", out_data, 17'd0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_in_ready_ena0", in_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check_bit("in_ready_ena0", in_ready, 1'b0);
        ena = 1'b1;
        #1;
        check_bit("in_ready_ena1", in_ready, 1'b1);

        // Known product, full throughput
        set_known();
        load(1'b0);
        check_bit("busy_in_calc", busy, 1'b1);
        check_bit("in_ready_calc", in_ready, 1'b0);
        wait_valid(lat);
        check_int("first_valid_latency", lat, 8);
        drain(1'b0);

`ifdef MATMUL_SIGNED_EN
        stim = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        expv = '{17'd32768, 17'd32768, 17'd32768, 17'd32768};
        load(1'b0);
        wait_valid(lat);
        check_int("neg128_latency", lat, 8);
        drain(1'b0);

        stim = '{8'd1, 8'hFE, 8'd3, 8'hFC, 8'd1, 8'd0, 8'd0, 8'd1};
        expv = '{17'd1, 17'h1FFFE, 17'd3, 17'h1FFFC};
        load(1'b0);
        wait_valid(lat);
        check_int("identity_latency", lat, 8);
        drain(1'b0);
`else
        stim = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        expv = '{17'd130050, 17'd130050, 17'd130050, 17'd130050};
        load(1'b0);
        wait_valid(lat);
        check_int("max_latency", lat, 8);
        drain(1'b0);
`endif

        // Input gaps plus output backpressure
        set_known();
        load(1'b1);
        wait_valid(lat);
        check_int("gap_latency", lat, 8);
        drain(1'b1);

        // Abort in the third CALC cycle
        load(1'b0);
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_in_ready", in_ready, 1'b1);
        check_bit("abort_out_valid", out_valid, 1'b0);
        check_bit("abort_done", done, 1'b0);
        quiet = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid === 1'b1 || done === 1'b1 || busy === 1'b1) quiet++;
        end
        check_int("abort_stays_idle", quiet, 0);
        load(1'b0);
        wait_valid(lat);
        check_int("reload_latency", lat, 8);
        drain(1'b0);

        // ena low for 5 cycles mid-CALC
        load(1'b0);
        step();
        step();
        ena = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check_bit("ena_hold_busy", busy, 1'b1);
        check_bit("ena_hold_valid", out_valid, 1'b0);
        ena = 1'b1;
        wait_valid(lat);
        check_int("ena_latency", lat + 7, 13);
        drain(1'b0);

        // Reset pulse mid-DRAIN
        load(1'b0);
        wait_valid(lat);
        check_int("pre_reset_latency", lat, 8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_data("pre_reset_out1", out_data, 17'd22);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_data("midrst_out_data", out_data, 17'd0);
        check_bit("midrst_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_bit("postrst_in_ready", in_ready, 1'b1);
        check_bit("postrst_out_valid", out_valid, 1'b0);
        load(1'b0);
        wait_valid(lat);
        check_int("postrst_latency", lat, 8);
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
